// File: rtl/mc_datapath.sv
// mc_datapath: multicycle processor datapath driven one control word per cycle
// by an external state-machine controller. Holds PC, IR, MDR, A, B, ALUout and
// an 8x16 register file (R0 is the accumulator), and talks to a single unified
// word memory whose read data is combinational with respect to mem_addr.
//
// Ports:
//   clk, rst                      rising-edge clock, async active-high reset
//   IorD, MEMread, MEMwrite,      1-bit control inputs from the controller
//   IRwrite, ALUsrcB, PCwrite,
//   regDst, regwrite, PCwritecond
//   ALUop, PCsrc, Memtoreg,       2-bit control inputs from the controller
//   ALUsrcA
//   mem_rdata                     memory read data (16)
//   mem_addr                      word address (12): IR[11:0] when IorD, else PC
//   mem_wdata                     store data (16), always A
//   mem_read, mem_write           pass-through of MEMread / MEMwrite
//   opcode, func                  IR[15:12], IR[8:0] back to the controller
//   pc_out                        current PC (12)
module mc_datapath #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IorD,
  input  logic        MEMread,
  input  logic        MEMwrite,
  input  logic        IRwrite,
  input  logic        ALUsrcB,
  input  logic        PCwrite,
  input  logic        regDst,
  input  logic        regwrite,
  input  logic        PCwritecond,
  input  logic [1:0]  ALUop,
  input  logic [1:0]  PCsrc,
  input  logic [1:0]  Memtoreg,
  input  logic [1:0]  ALUsrcA,
  input  logic [15:0] mem_rdata,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  opcode,
  output logic [8:0]  func,
  output logic [11:0] pc_out
);

  logic [11:0] pc;
  logic [15:0] ir;
  logic [15:0] mdr;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] alu_out;
  logic [15:0] rf [8];

  logic [2:0]  ri;
  logic [15:0] imm_ext;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [15:0] alu_res;
  logic        zero;
  logic [11:0] pc_next;
  logic        pc_load;
  logic [2:0]  wr_idx;
  logic [15:0] wr_data;

  assign ri      = ir[11:9];
  assign imm_ext = {{4{ir[11]}}, ir[11:0]};

  assign opcode    = ir[15:12];
  assign func      = ir[8:0];
  assign pc_out    = pc;
  assign mem_wdata = a;
  assign mem_read  = MEMread;
  assign mem_write = MEMwrite;

  // IR is cleared during reset, so the IorD path would already read 0; forcing
  // RESET_PC keeps the address correct for any non-zero reset vector.
  always_comb begin
    mem_addr = IorD ? ir[11:0] : pc;
    if (rst) mem_addr = RESET_PC;
  end

  always_comb begin
    alu_x = '0;
    unique case (ALUsrcA)
      2'b00: alu_x = {4'b0000, pc};
      2'b01: alu_x = a;
      2'b10: alu_x = b;
      2'b11: alu_x = '0;
    endcase
    alu_y = ALUsrcB ? 16'h0001 : imm_ext;
  end

  // ALUop 10 and 11 work directly on A/B; the X/Y muxes are ignored there.
  always_comb begin
    alu_res = '0;
    unique case (ALUop)
      2'b00: alu_res = alu_x + alu_y;
      2'b01: begin
        unique case (ir[13:12])
          2'b00: alu_res = alu_x + alu_y;
          2'b01: alu_res = alu_x - alu_y;
          2'b10: alu_res = alu_x & alu_y;
          2'b11: alu_res = alu_x | alu_y;
        endcase
      end
      2'b10: alu_res = a;
      2'b11: begin
        case (ir[8:0])
          9'h004:  alu_res = a + b;
          9'h008:  alu_res = a - b;
          9'h010:  alu_res = a & b;
          9'h020:  alu_res = a | b;
          9'h040:  alu_res = ~a;
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  assign zero = (alu_res == '0);

  always_comb begin
    pc_next = alu_res[11:0];
    unique case (PCsrc)
      2'b00: pc_next = alu_res[11:0];
      2'b01: pc_next = ir[11:0];
      2'b10: pc_next = ir[11:0];
      2'b11: pc_next = alu_out[11:0];
    endcase
    pc_load = PCwrite | (PCwritecond & zero);
  end

  always_comb begin
    wr_idx  = regDst ? ri : 3'd0;
    wr_data = alu_out;
    unique case (Memtoreg)
      2'b00: wr_data = alu_out;
      2'b01: wr_data = mdr;
      2'b10: wr_data = b;
      2'b11: wr_data = a;
    endcase
  end

  // A/B sample the register file before this edge's write lands, giving the
  // one-cycle read-after-write delay the controller sequences rely on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      for (int unsigned i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      mdr     <= mem_rdata;
      a       <= rf[0];
      b       <= rf[ri];
      alu_out <= alu_res;
      if (IRwrite)  ir         <= mem_rdata;
      if (pc_load)  pc         <= pc_next;
      if (regwrite) rf[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IorD = 1'b0, MEMread = 1'b0, MEMwrite = 1'b0, IRwrite = 1'b0;
  logic        ALUsrcB = 1'b0, PCwrite = 1'b0, regDst = 1'b0, regwrite = 1'b0;
  logic        PCwritecond = 1'b0;
  logic [1:0]  ALUop = '0, PCsrc = '0, Memtoreg = '0, ALUsrcA = '0;
  logic [15:0] mem_rdata;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read, mem_write;
  logic [3:0]  opcode;
  logic [8:0]  func;
  logic [11:0] pc_out;

  logic [15:0] mem [4096];
  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  mc_datapath #(.RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst), .IorD(IorD), .MEMread(MEMread), .MEMwrite(MEMwrite),
    .IRwrite(IRwrite), .ALUsrcB(ALUsrcB), .PCwrite(PCwrite), .regDst(regDst),
    .regwrite(regwrite), .PCwritecond(PCwritecond), .ALUop(ALUop), .PCsrc(PCsrc),
    .Memtoreg(Memtoreg), .ALUsrcA(ALUsrcA), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .opcode(opcode), .func(func), .pc_out(pc_out)
  );

  int total = 0;
  int bad   = 0;

  // Architectural reference: PC, register file and memory per instruction.
  logic [11:0] m_pc;
  logic [15:0] m_rf [8];
  logic [11:0] exp_st_addr;
  logic [15:0] exp_st_data;

  // Observations recorded while a bench-controller sequence runs.
  logic [3:0]  ob_op;
  logic [8:0]  ob_func;
  logic [11:0] ob_fetch_pc;
  logic        ob_st_wr;
  logic [11:0] ob_st_addr;
  logic [15:0] ob_st_data;

  task automatic idle_ctl();
    IorD = 0; MEMread = 0; MEMwrite = 0; IRwrite = 0; ALUsrcB = 0; PCwrite = 0;
    regDst = 0; regwrite = 0; PCwritecond = 0;
    ALUop = '0; PCsrc = '0; Memtoreg = '0; ALUsrcA = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ctl();
    idle_ctl();
    MEMread = 1; IRwrite = 1; ALUsrcA = 2'b00; ALUsrcB = 1; ALUop = 2'b00;
    PCsrc = 2'b00; PCwrite = 1;
  endtask

  task automatic model_reset();
    m_pc = 12'h000;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
  endtask

  // Instruction set seen by the bench controller:
  //   0 load R0<-mem[t]   1 store mem[t]<-R0   2 jump t   3 jump t via ALUout
  //   4 beqz R0,t   5 R0<-R[ri]+1   8 R-type on func   C/D/E/F R0 op= sext(imm)
  task automatic model_exec(input logic [15:0] w);
    logic [3:0]  op;
    logic [2:0]  r;
    logic [8:0]  f;
    logic [11:0] t;
    logic [15:0] s;
    int          si;
    op = w[15:12]; r = w[11:9]; f = w[8:0]; t = w[11:0];
    si = (int'(t) >= 2048) ? int'(t) - 4096 : int'(t);
    s  = 16'(si);
    m_pc = m_pc + 12'd1;
    case (op)
      4'h0: m_rf[0] = mem[t];
      4'h1: begin
        exp_st_addr = t;
        exp_st_data = m_rf[0];
        mem[t] = m_rf[0];
      end
      4'h2, 4'h3: m_pc = t;
      4'h4: if (m_rf[0] == 16'h0000) m_pc = t;
      4'h5: m_rf[0] = m_rf[r] + 16'd1;
      4'h8: begin
        case (f)
          9'h001:  m_rf[0] = m_rf[r];
          9'h002:  m_rf[r] = m_rf[0];
          9'h004:  m_rf[0] = m_rf[0] + m_rf[r];
          9'h008:  m_rf[0] = m_rf[0] - m_rf[r];
          9'h010:  m_rf[0] = m_rf[0] & m_rf[r];
          9'h020:  m_rf[0] = m_rf[0] | m_rf[r];
          9'h040:  m_rf[0] = ~m_rf[0];
          default: m_rf[0] = 16'h0000;
        endcase
      end
      4'hC: m_rf[0] = m_rf[0] + s;
      4'hD: m_rf[0] = m_rf[0] - s;
      4'hE: m_rf[0] = m_rf[0] & s;
      4'hF: m_rf[0] = m_rf[0] | s;
      default: ;
    endcase
  endtask

  // Bench controller: fetch, decode, execute sequence, one idle cycle, then
  // the reference model is advanced.
  task automatic run_instr(input logic [15:0] w);
    mem[m_pc] = w;
    ob_st_wr = 0; ob_st_addr = '0; ob_st_data = '0;
    fetch_ctl();
    tick();
    ob_op = opcode; ob_func = func; ob_fetch_pc = pc_out;
    idle_ctl();
    tick();
    case (w[15:12])
      4'h0: begin
        idle_ctl(); IorD = 1; MEMread = 1; tick();
        idle_ctl(); regwrite = 1; regDst = 0; Memtoreg = 2'b01; tick();
      end
      4'h1: begin
        idle_ctl(); IorD = 1; MEMwrite = 1;
        #2;
        ob_st_wr = mem_write; ob_st_addr = mem_addr; ob_st_data = mem_wdata;
        tick();
      end
      4'h2: begin
        idle_ctl(); PCwrite = 1; PCsrc = 2'b10; tick();
      end
      4'h3: begin
        idle_ctl(); ALUsrcA = 2'b11; ALUsrcB = 0; ALUop = 2'b00; tick();
        idle_ctl(); PCwrite = 1; PCsrc = 2'b11; tick();
      end
      4'h4: begin
        idle_ctl(); ALUop = 2'b10; PCwritecond = 1; PCsrc = 2'b01;
        ALUsrcA = 2'($urandom); ALUsrcB = 1'($urandom); tick();
      end
      4'h5: begin
        idle_ctl(); ALUsrcA = 2'b10; ALUsrcB = 1; ALUop = 2'b00; tick();
        idle_ctl(); regwrite = 1; Memtoreg = 2'b00; tick();
      end
      4'h8: begin
        if (w[8:0] == 9'h001) begin
          idle_ctl(); regwrite = 1; regDst = 0; Memtoreg = 2'b10; tick();
        end else if (w[8:0] == 9'h002) begin
          idle_ctl(); regwrite = 1; regDst = 1; Memtoreg = 2'b11; tick();
        end else begin
          idle_ctl(); ALUop = 2'b11; ALUsrcA = 2'($urandom); ALUsrcB = 1'($urandom); tick();
          idle_ctl(); regwrite = 1; Memtoreg = 2'b00; tick();
        end
      end
      4'hC, 4'hD, 4'hE, 4'hF: begin
        idle_ctl(); ALUsrcA = 2'b01; ALUsrcB = 0; ALUop = 2'b01; tick();
        idle_ctl(); regwrite = 1; Memtoreg = 2'b00; tick();
      end
      default: ;
    endcase
    idle_ctl();
    tick();
    model_exec(w);
  endtask

  task automatic test_reset();
    rst = 1;
    idle_ctl(); IorD = 1; MEMread = 1; MEMwrite = 0;
    #2;
    total++; if (pc_out !== 12'h000) begin bad++; $display("FAIL reset_pc: got %h want %h", pc_out, 12'h000); end
    total++; if (opcode !== 4'h0) begin bad++; $display("FAIL reset_opcode: got %h want %h", opcode, 4'h0); end
    total++; if (func !== 9'h000) begin bad++; $display("FAIL reset_func: got %h want %h", func, 9'h000); end
    total++; if (mem_addr !== 12'h000) begin bad++; $display("FAIL reset_mem_addr: got %h want %h", mem_addr, 12'h000); end
    total++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin bad++; $display("FAIL reset_passthru_a: got rd=%b wr=%b want rd=1 wr=0", mem_read, mem_write); end
    MEMread = 0; MEMwrite = 1;
    #1;
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b1) begin bad++; $display("FAIL reset_passthru_b: got rd=%b wr=%b want rd=0 wr=1", mem_read, mem_write); end
    fetch_ctl();
    tick();
    tick();
    total++; if (pc_out !== 12'h000 || mem_wdata !== 16'h0000) begin bad++; $display("FAIL reset_hold: got pc=%h a=%h want 000/0000", pc_out, mem_wdata); end
    idle_ctl();
    #2;
    rst = 0;
    model_reset();
  endtask

  task automatic test_fetch();
    mem[0] = 16'h1005;
    fetch_ctl();
    tick();
    total++; if (pc_out !== 12'h001) begin bad++; $display("FAIL fetch_pc: got %h want %h", pc_out, 12'h001); end
    total++; if (opcode !== 4'h1) begin bad++; $display("FAIL fetch_opcode: got %h want %h", opcode, 4'h1); end
    total++; if (func !== 9'h005) begin bad++; $display("FAIL fetch_func: got %h want %h", func, 9'h005); end
    idle_ctl();
    tick();
    m_pc = 12'h001;
  endtask

  task automatic test_load_add_store();
    mem[5] = 16'h0007;
    run_instr(16'h0005);
    total++; if (mem_wdata !== 16'h0007) begin bad++; $display("FAIL load_r0: got %h want %h", mem_wdata, 16'h0007); end
    run_instr(16'hC003);
    total++; if (mem_wdata !== 16'h000A) begin bad++; $display("FAIL addi_r0: got %h want %h", mem_wdata, 16'h000A); end
    run_instr(16'h1006);
    total++; if (ob_st_wr !== 1'b1) begin bad++; $display("FAIL store_we: got %b want 1", ob_st_wr); end
    total++; if (ob_st_addr !== 12'h006) begin bad++; $display("FAIL store_addr: got %h want %h", ob_st_addr, 12'h006); end
    total++; if (ob_st_data !== 16'h000A) begin bad++; $display("FAIL store_data: got %h want %h", ob_st_data, 16'h000A); end
  endtask

  task automatic test_branch();
    run_instr(16'h8100);
    run_instr(16'h4020);
    total++; if (pc_out !== 12'h020) begin bad++; $display("FAIL branch_taken: got %h want %h", pc_out, 12'h020); end
    run_instr(16'hC003);
    run_instr(16'h4020);
    total++; if (pc_out !== 12'h022) begin bad++; $display("FAIL branch_not_taken: got %h want %h", pc_out, 12'h022); end
  endtask

  task automatic test_rtype();
    run_instr(16'h8100);
    run_instr(16'hC004);
    run_instr(16'h8602);
    run_instr(16'h8100);
    run_instr(16'hC009);
    total++; if (mem_wdata !== 16'h0009) begin bad++; $display("FAIL rtype_setup: got %h want %h", mem_wdata, 16'h0009); end
    run_instr(16'h8608);
    total++; if (mem_wdata !== 16'h0005) begin bad++; $display("FAIL rtype_sub: got %h want %h", mem_wdata, 16'h0005); end
    run_instr(16'h8602);
    run_instr(16'hC001);
    total++; if (mem_wdata !== 16'h0006) begin bad++; $display("FAIL rtype_addi: got %h want %h", mem_wdata, 16'h0006); end
    run_instr(16'h8601);
    total++; if (mem_wdata !== 16'h0005) begin bad++; $display("FAIL rtype_mov: got %h want %h", mem_wdata, 16'h0005); end
  endtask

  task automatic test_wrap_jump();
    run_instr(16'h2FFF);
    total++; if (pc_out !== 12'hFFF) begin bad++; $display("FAIL jump_fff: got %h want %h", pc_out, 12'hFFF); end
    run_instr(16'h2ABC);
    total++; if (ob_fetch_pc !== 12'h000) begin bad++; $display("FAIL pc_wrap: got %h want %h", ob_fetch_pc, 12'h000); end
    total++; if (pc_out !== 12'hABC) begin bad++; $display("FAIL jump_abc: got %h want %h", pc_out, 12'hABC); end
  endtask

  task automatic test_random();
    logic [3:0]  ops [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h8, 4'hC, 4'hD, 4'hE, 4'hF};
    logic [8:0]  fns [8]  = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h000};
    logic [15:0] w;
    for (int n = 0; n < 300; n++) begin
      w[15:12] = ops[$urandom_range(11, 0)];
      w[11:0]  = 12'($urandom);
      if (w[15:12] == 4'h8) begin
        w[8:0] = fns[$urandom_range(7, 0)];
        if (w[8:0] == 9'h000) w[8:0] = 9'($urandom);
      end
      if ($urandom_range(9, 0) == 0) w = 16'h8100;
      run_instr(w);
      total++; if (ob_op !== w[15:12] || ob_func !== w[8:0]) begin bad++; $display("FAIL rnd_ir n=%0d: got %h/%h want %h/%h", n, ob_op, ob_func, w[15:12], w[8:0]); end
      total++; if (pc_out !== m_pc) begin bad++; $display("FAIL rnd_pc n=%0d w=%h: got %h want %h", n, w, pc_out, m_pc); end
      total++; if (mem_wdata !== m_rf[0]) begin bad++; $display("FAIL rnd_r0 n=%0d w=%h: got %h want %h", n, w, mem_wdata, m_rf[0]); end
      if (w[15:12] == 4'h1) begin
        total++; if (ob_st_wr !== 1'b1 || ob_st_addr !== exp_st_addr || ob_st_data !== exp_st_data) begin
          bad++; $display("FAIL rnd_store n=%0d: got we=%b %h<-%h want %h<-%h", n, ob_st_wr, ob_st_addr, ob_st_data, exp_st_addr, exp_st_data);
        end
      end
    end
  endtask

  task automatic test_regfile_dump();
    logic [15:0] want;
    for (int k = 1; k < 8; k++) begin
      want = m_rf[k];
      run_instr({4'h8, 3'(k), 9'h001});
      total++; if (mem_wdata !== want) begin bad++; $display("FAIL dump_r%0d: got %h want %h", k, mem_wdata, want); end
    end
  endtask

  task automatic test_reset_mid();
    run_instr(16'h8100);
    run_instr(16'hC00F);
    mem[m_pc] = 16'h8602;
    fetch_ctl();
    tick();
    idle_ctl();
    tick();
    idle_ctl(); regwrite = 1; regDst = 1; Memtoreg = 2'b11;
    #3;
    rst = 1;
    #1;
    total++; if (pc_out !== 12'h000 || opcode !== 4'h0 || func !== 9'h000) begin bad++; $display("FAIL async_rst_ctl: got pc=%h op=%h fn=%h want 000/0/000", pc_out, opcode, func); end
    total++; if (mem_wdata !== 16'h0000) begin bad++; $display("FAIL async_rst_a: got %h want %h", mem_wdata, 16'h0000); end
    tick();
    idle_ctl();
    #2;
    rst = 0;
    model_reset();
    tick();
    total++; if (mem_wdata !== 16'h0000) begin bad++; $display("FAIL async_rst_r0: got %h want %h", mem_wdata, 16'h0000); end
    run_instr(16'h8601);
    total++; if (mem_wdata !== 16'h0000) begin bad++; $display("FAIL async_rst_no_write: got %h want %h", mem_wdata, 16'h0000); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    model_reset();
    exp_st_addr = '0; exp_st_data = '0;
    test_reset();
    test_fetch();
    test_load_add_store();
    test_branch();
    test_rtype();
    test_wrap_jump();
    test_random();
    test_regfile_dump();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multicycle datapath that executes the control words produced by the processor's state-machine controller. It holds PC, IR, MDR, A, B, ALUout and an 8×16 register file, and drives a single external unified word memory. It returns opcode and func from IR to the controller. One instruction completes over several cycles, one control word per cycle.

## Interface
- RESET_PC, 12'h000, PC value after reset

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- IorD, MEMread, MEMwrite, IRwrite, ALUsrcB, PCwrite, regDst, regwrite, PCwritecond  in  1 each  control from controller
- ALUop, PCsrc, Memtoreg, ALUsrcA  in  2 each  control from controller
- mem_rdata  in  16  memory read data, combinational w.r.t. mem_addr
- mem_addr  out  12  word address
- mem_wdata  out  16  store data
- mem_read, mem_write  out  1  copies of MEMread, MEMwrite
- opcode  out  4  IR[15:12]
- func  out  9  IR[8:0]
- pc_out  out  12  current PC

## Operation
- Instruction fields:
  - opcode = IR[15:12]
  - ri = IR[11:9]
  - func = IR[8:0]
  - imm = IR[11:0], sign-extended to 16 bits
  - target = IR[11:0]
- R0 is the accumulator.
- Memory interface:
  - mem_addr = IorD ? IR[11:0] : PC.
  - mem_wdata = A.
- Registers loaded every cycle:
  - MDR <= mem_rdata
  - A <= R0
  - B <= R[ri]
  - ALUout <= ALU result
- IRwrite=1: IR <= mem_rdata.
- ALU operand X (ALUsrcA): 00 {4'b0,PC}; 01 A; 10 B; 11 16'h0000.
- ALU operand Y (ALUsrcB): 0 imm; 1 16'h0001.
- ALU function by ALUop:
  - 00: X+Y.
  - 01: by opcode[1:0]: 00 X+Y, 01 X−Y, 10 X&Y, 11 X|Y.
  - 10: result = A. zero = (A==0).
  - 11: uses A and B, ignoring X/Y. func one-hot: bit2 A+B, bit3 A−B, bit4 A&B, bit5 A|B, bit6 ~A; any other func gives 16'h0000.
- All arithmetic is 16-bit modulo; there are no flags other than zero.
- zero = (ALU result == 0), combinational.
- PC next value by PCsrc: 00 ALU result[11:0]; 01 target; 10 target; 11 ALUout[11:0].
- PC load condition: PCwrite | (PCwritecond & zero). PCwrite alone forces the load.
- Register file write (regwrite=1):
  - Destination: regDst=0 → R0; regDst=1 → R[ri].
  - Data by Memtoreg: 00 ALUout; 01 MDR; 10 B; 11 A.
- MEMwrite=1: mem_write asserted, storing A at IR[11:0]. No internal memory.

## Timing
- Reset (asynchronous) sets PC=RESET_PC and clears IR, MDR, A, B, ALUout and R0–R7 to 0.
- Output values while rst is held:
  - opcode=0, func=0
  - mem_addr=RESET_PC
  - mem_read=MEMread, mem_write=MEMwrite (pass-through)
- Reset mid-instruction discards all state; no partial write completes after rst asserts.
- All register updates occur on the rising clk edge and are visible the next cycle.
- Read-during-write: a register written at edge k is seen by A/B at edge k+1, not k. A and B capture the old value at edge k.
- Latency seen from controller inputs:
  - IR valid (opcode/func) one cycle after the IRwrite cycle.
  - MDR valid one cycle after the MEMread/IorD=1 cycle.
  - ALUout holds the result of the previous cycle.
- PC wraps: 12'hFFF + 1 = 12'h000, because only bits [11:0] are kept.
- Simultaneous IRwrite and IorD=1: IR loads the data word. This is legal; the controller never issues it.
- Both control inputs and mem_rdata are sampled only at the clock edge. mem_addr is combinational from PC/IR/IorD.

## Test plan
- Reset then fetch:
  - Stimulus: rst pulse, mem[0]=16'h1005; drive IF control word (IorD=0, MEMread, IRwrite, ALUsrcA=00, ALUsrcB=1, PCsrc=00, PCwrite).
  - Required response: PC=1, opcode=4'h1, func=9'h005 after one edge.
- Load/add/store:
  - Stimulus: mem[5]=16'h0007; execute load (0005), addi (C003), store (1006) with their controller sequences.
  - Required response: R0=7, then R0=10; mem_write with mem_addr=6, mem_wdata=16'h000A.
- Branch:
  - Stimulus: opcode 0100 target 12'h020, once with R0=0 and once with R0=3.
  - Required response: PC=12'h020 when R0=0; PC unchanged (fall-through) when R0=3.
- R-type:
  - Stimulus: R0=9, R3=4.
  - Required responses:
    - func=9'h008 (sub): R0=5.
    - func=9'h002 with regDst=1: R3 gets R0.
    - func=9'h001: R0 gets R3.
- PC wrap and jump:
  - Stimulus: PC=12'hFFF fetch; then jump 2ABC.
  - Required response: PC=0 after the fetch; PC=12'hABC after the jump.
- Asynchronous reset mid-instruction:
  - Stimulus: assert rst between clock edges while regwrite is pending.
  - Required response: all registers 0 immediately; no write is performed.
